bp_update_ctrl: RTL

- Sequences all writes into the branch predictor tables (BTB plus gshare PHT) through a single shared write port.
- Buffers resolved-branch updates from EX in a small FIFO and computes the new saturating counter value for each one.
- Runs a clear sweep over every table entry after reset and on request, blocking predictions while the sweep is in progress.
- Sits between the EX stage and the predictor tables; the table's write port applies back-pressure through wr_ready.

---
 rtl/bp_update_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl
// Owns the single write port of the branch predictor tables (BTB + gshare PHT).
// Resolved-branch updates from EX are buffered in a small in-order FIFO.
// The new 2-bit saturating counter is computed at enqueue time.
// After reset, or on clear_req, the block sweeps every table index with a
// clear write and holds predict_disable high until the sweep completes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   upd_*                    EX-stage update request and payload
//   wb_flush                 kills the EX update presented in the same cycle
//   clear_req                one-cycle pulse: flush the FIFO and restart the sweep
//   wr_ready                 table write port accepts the current write
//   wr_*                     table write request (clear sweep or FIFO head)
//   predict_disable          force predictions not-taken during the sweep
//   fifo_count               registered FIFO occupancy, 0..FIFO_DEPTH
//   ovf                      one-cycle pulse: an update was dropped on a full FIFO
module bp_update_ctrl #(
    parameter int IDX_BITS   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        upd_br_inst,
    input  logic                        upd_target_valid,
    input  logic                        upd_br_taken,
    input  logic                        upd_is_uncond,
    input  logic [31:0]                 upd_addr,
    input  logic [31:0]                 upd_target,
    input  logic [IDX_BITS-1:0]         upd_idx,
    input  logic [1:0]                  upd_sc,
    input  logic                        wb_flush,
    input  logic                        clear_req,
    input  logic                        wr_ready,
    output logic                        wr_en,
    output logic                        wr_clear,
    output logic                        wr_pht_en,
    output logic                        wr_btb_en,
    output logic [IDX_BITS-1:0]         wr_idx,
    output logic [1:0]                  wr_sc,
    output logic [31:0]                 wr_addr,
    output logic [31:0]                 wr_target,
    output logic                        wr_is_uncond,
    output logic                        predict_disable,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]       FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [IDX_BITS-1:0] LAST_IDX   = '1;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic                pht_en;
        logic                btb_en;
        logic                is_uncond;
        logic [IDX_BITS-1:0] idx;
        logic [1:0]          sc;
        logic [31:0]         addr;
        logic [31:0]         target;
    } entry_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] sweep_idx_q, sweep_idx_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    entry_t              mem_q [FIFO_DEPTH];

    entry_t head;
    entry_t new_entry;
    logic   full;
    logic   empty;
    logic   upd_req;
    logic   pop;
    logic   push;

    function automatic logic [1:0] next_sc(input logic [1:0] sc, input logic taken);
        if (taken) begin
            return (sc == 2'b11) ? 2'b11 : sc + 2'b01;
        end
        return (sc == 2'b00) ? 2'b00 : sc - 2'b01;
    endfunction

    always_comb begin
        full    = (count_q == FULL_COUNT);
        empty   = (count_q == '0);
        upd_req = (state_q == RUN) && !clear_req && !wb_flush
                  && (upd_br_inst || upd_target_valid);
        pop     = (state_q == RUN) && !empty && wr_ready;
        // A full FIFO still takes a new entry when the head leaves this cycle.
        push    = upd_req && (!full || pop);
        head    = mem_q[rd_ptr_q];

        new_entry           = '0;
        new_entry.pht_en    = upd_br_inst;
        new_entry.btb_en    = upd_target_valid;
        new_entry.is_uncond = upd_is_uncond;
        new_entry.idx       = upd_idx;
        new_entry.sc        = next_sc(upd_sc, upd_br_taken);
        new_entry.addr      = upd_addr;
        new_entry.target    = upd_target;
    end

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        ovf_d       = 1'b0;

        if (clear_req) begin
            state_d     = SWEEP;
            sweep_idx_d = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end else if (state_q == SWEEP) begin
            if (wr_ready) begin
                if (sweep_idx_q == LAST_IDX) begin
                    state_d     = RUN;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_BITS'(1);
                end
            end
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            ovf_d = upd_req && !push;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // Payload storage needs no reset: entries are only read behind count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // All write-port outputs derive from registered state. The rst term keeps
    // wr_en low while reset is held, even though the state already reads SWEEP.
    always_comb begin
        predict_disable = (state_q == SWEEP);
        fifo_count      = count_q;
        ovf             = ovf_q;
        if (state_q == SWEEP) begin
            wr_en        = !rst;
            wr_clear     = 1'b1;
            wr_pht_en    = 1'b1;
            wr_btb_en    = 1'b1;
            wr_idx       = sweep_idx_q;
            wr_sc        = 2'b01;
            wr_addr      = '0;
            wr_target    = '0;
            wr_is_uncond = 1'b0;
        end else begin
            wr_en        = !empty && !rst;
            wr_clear     = 1'b0;
            wr_pht_en    = head.pht_en;
            wr_btb_en    = head.btb_en;
            wr_idx       = head.idx;
            wr_sc        = head.sc;
            wr_addr      = head.addr;
            wr_target    = head.target;
            wr_is_uncond = head.is_uncond;
        end
    end

endmodule
